vram_buffer_dual: RTL and testbench
===================================

VRAM_BUFFER_DUAL -- requirements
Module: vram_buffer_dual

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: pixel columns per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: lines per frame.
REQ-003 SHALL have parameter PIX_W, default 1 (legal 1..12): bits per pixel.
REQ-004 SHALL have ports:
  Reloj  in  1  clock, sole clock domain; all logic on its rising edge.
  Reset  in  1  synchronous, active-high reset.
  Fila  in  11  read row.
  Columna  in  11  read column.
  LeerValido  in  1  read request this cycle.
  Pixel  out  PIX_W  read data.
  PixelValido  out  1  Pixel valid.
  FueraRango  out  1  read address was out of range.
  EscFila  in  11  write row.
  EscColumna  in  11  write column.
  EscDato  in  PIX_W  write data.
  EscValido  in  1  write offered.
  EscListo  out  1  write accepted when high with EscValido.
  Intercambio  in  1  bank-swap request pulse.
  FinCuadro  in  1  end-of-frame pulse from the sync generator.
  BancoActivo  out  1  bank currently displayed.

Function
REQ-005 SHALL compute the linear address as Fila*H_ACTIVE+Columna, width $clog2(H_ACTIVE*V_ACTIVE).
REQ-006 SHALL treat Fila>=V_ACTIVE or Columna>=H_ACTIVE as out of range.
REQ-007 SHALL pipeline reads in two stages: stage 1 registers address and range flag; stage 2 registers memory data.
REQ-008 SHALL assert PixelValido exactly 2 cycles after LeerValido, one pulse per request, accepting a request every cycle.
REQ-009 SHALL output Pixel=0 and FueraRango=1 with PixelValido for an out-of-range read, without accessing memory.
REQ-010 SHALL accept a write when EscValido&&EscListo, storing EscDato in the same cycle, and silently drop out-of-range writes.
REQ-011 SHALL return old data when a read and a write hit the same address in the same cycle (read-first).
REQ-012 SHALL implement FSM states VR_CLEAR and VR_IDLE: VR_CLEAR writes 0 to one address per cycle, from 0 to H_ACTIVE*V_ACTIVE-1, then enters VR_IDLE.
REQ-013 SHALL hold EscListo=0 in VR_CLEAR and EscListo=1 in VR_IDLE.
REQ-014 SHALL service reads during VR_CLEAR normally, with Pixel forced to 0.
REQ-015 SHALL treat simultaneous reads and writes as independent; only the clear engine overrides the write port.

Reset
REQ-016 SHALL on Reset force PixelValido=0, FueraRango=0, Pixel=0, EscListo=0, BancoActivo=0, swap-pending=0, and flush both pipeline stages.
REQ-017 SHALL enter VR_CLEAR at address 0 on the cycle after Reset deasserts; Reset during VR_CLEAR restarts the sweep at address 0.

Configuration
REQ-018 SHALL, with VRAM_DOUBLE_BUFFER_EN defined, instantiate two banks: reads from bank BancoActivo, writes to bank !BancoActivo.
REQ-019 SHALL, with the macro defined, latch Intercambio into swap-pending and toggle BancoActivo on the first FinCuadro while pending, clearing pending; Intercambio and FinCuadro in the same cycle swap on that cycle.
REQ-020 SHALL, with the macro defined, clear both banks in parallel during VR_CLEAR.
REQ-021 SHALL, without the macro, use one bank for reads and writes, ignore Intercambio and FinCuadro, and hold BancoActivo=0.

Structure
REQ-022 SHALL place the H_ACTIVE/V_ACTIVE/PIX_W defaults, the FSM state enum and the address-width constant in package vram_pkg.
REQ-023 SHALL implement storage as sub-module vram_bank: one write port and one synchronous read port (read-first), instantiated once or twice.

Verification
REQ-024 Reset for 1 cycle -> EscListo low for exactly 307200 cycles (640x480), then high; every in-range read returns 0.
REQ-025 Write (Fila 10, Columna 20, data 1); read the same position 3 cycles later -> Pixel=1, PixelValido 2 cycles after LeerValido.
REQ-026 Read Fila 480, Columna 0 -> Pixel=0, FueraRango=1; write to Columna 640 -> memory unchanged.
REQ-027 Back-to-back reads at addresses 0..15 -> 16 consecutive PixelValido pulses in order; read and write to the same address in the same cycle -> old value.
REQ-028 With VRAM_DOUBLE_BUFFER_EN: write 1 at (0,0), read -> 0; pulse Intercambio, then FinCuadro -> BancoActivo=1, read -> 1.
REQ-029 Reset asserted mid-clear at address 1000 -> sweep restarts at 0, with the full 307200-cycle EscListo-low period.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared defaults, FSM state type and address-width helper for the VRAM buffer
//
// Purpose : Frame geometry defaults, the clear/idle state enum and the
//           linear-address width used by vram_buffer_dual and vram_bank.
// Ports   : none (package).

package vram_pkg;

  localparam int VR_H_ACTIVE = 640;
  localparam int VR_V_ACTIVE = 480;
  localparam int VR_PIX_W    = 1;

  typedef enum logic {
    VR_CLEAR = 1'b0,
    VR_IDLE  = 1'b1
  } vr_state_t;

  // Width of a linear pixel address for an h x v frame (never below 1 bit).
  function automatic int vram_addr_w(input int h, input int v);
    return (h * v > 1) ? $clog2(h * v) : 1;
  endfunction

  localparam int VR_ADDR_W = vram_addr_w(VR_H_ACTIVE, VR_V_ACTIVE);

endpackage

// File: rtl/vram_bank.sv
// rtl/vram_bank.sv - single frame-store bank, one write port and one registered read port
//
// Purpose : Pixel storage. A read and a write to the same address in the
//           same cycle return the value held before the write (read-first).
// Ports   : i_clk                      clock
//           i_we / i_waddr / i_wdata   write port
//           i_re / i_raddr             read request, address
//           o_rdata                    read data, one cycle after i_re

module vram_bank #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 1
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // Both accesses use non-blocking updates, so a same-cycle read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_buffer_dual.sv
// rtl/vram_buffer_dual.sv - video frame buffer with clear-on-reset and optional double buffering
//
// Purpose : Pixel store addressed by (row, column) with a two-stage read
//           pipeline, a single write port and a power-up clear sweep.
//           Optional macro VRAM_DOUBLE_BUFFER_EN adds a second bank:
//           display reads bank BancoActivo, writes go to the other bank,
//           and a requested swap takes effect on the next end-of-frame pulse.
// Ports   : Reloj, Reset                         clock, sync active-high reset
//           Fila, Columna, LeerValido            read request
//           Pixel, PixelValido, FueraRango       read response (2 cycles later)
//           EscFila, EscColumna, EscDato,
//           EscValido, EscListo                  write handshake
//           Intercambio, FinCuadro, BancoActivo  bank swap control / status

module vram_buffer_dual
  import vram_pkg::*;
#(
  parameter int H_ACTIVE = VR_H_ACTIVE,
  parameter int V_ACTIVE = VR_V_ACTIVE,
  parameter int PIX_W    = VR_PIX_W
) (
  input  logic             Reloj,
  input  logic             Reset,
  input  logic [10:0]      Fila,
  input  logic [10:0]      Columna,
  input  logic             LeerValido,
  output logic [PIX_W-1:0] Pixel,
  output logic             PixelValido,
  output logic             FueraRango,
  input  logic [10:0]      EscFila,
  input  logic [10:0]      EscColumna,
  input  logic [PIX_W-1:0] EscDato,
  input  logic             EscValido,
  output logic             EscListo,
  input  logic             Intercambio,
  input  logic             FinCuadro,
  output logic             BancoActivo
);

  localparam int                DEPTH     = H_ACTIVE * V_ACTIVE;
  localparam int                ADDR_W    = vram_addr_w(H_ACTIVE, V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       H_LIM     = 32'(H_ACTIVE);
  localparam logic [31:0]       V_LIM     = 32'(V_ACTIVE);

  // Address decode. An out-of-range address may alias a legal one after
  // truncation, so it is only ever used together with its range flag.
  logic              w_rd_oor;
  logic              w_wr_oor;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_rd_oor  = (32'(Fila) >= V_LIM) || (32'(Columna) >= H_LIM);
  assign w_wr_oor  = (32'(EscFila) >= V_LIM) || (32'(EscColumna) >= H_LIM);
  assign w_rd_addr = ADDR_W'(Fila) * ADDR_W'(H_ACTIVE) + ADDR_W'(Columna);
  assign w_wr_addr = ADDR_W'(EscFila) * ADDR_W'(H_ACTIVE) + ADDR_W'(EscColumna);

  // Clear / idle FSM
  vr_state_t         r_state;
  vr_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              w_clr_we;
  logic              w_esc_listo;

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      r_state    <= VR_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_we       = 1'b0;
    w_esc_listo    = 1'b0;
    case (r_state)
      VR_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt    = VR_IDLE;
          w_clr_addr_nxt = '0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        end
      end
      VR_IDLE: begin
        w_esc_listo = 1'b1;
      end
      default: begin
        w_state_nxt = VR_CLEAR;
      end
    endcase
  end

  assign EscListo = w_esc_listo;

  // Shared write-port mux: the clear engine owns the port while sweeping,
  // and EscListo is low then, so the two sources never collide.
  logic              w_wr_fire;
  logic [ADDR_W-1:0] w_we_addr;
  logic [PIX_W-1:0]  w_we_data;
  logic              w_rd_en;
  logic [PIX_W-1:0]  w_rd_data;

  assign w_wr_fire = EscValido && w_esc_listo && !w_wr_oor;
  assign w_we_addr = w_clr_we ? r_clr_addr : w_wr_addr;
  assign w_we_data = w_clr_we ? '0 : EscDato;
  // The bank is read in the request cycle so a same-cycle write is not seen.
  assign w_rd_en   = LeerValido && !w_rd_oor;

`ifdef VRAM_DOUBLE_BUFFER_EN
  logic             r_banco;
  logic             r_pending;
  logic             r_s1_bank;
  logic [PIX_W-1:0] w_rdata0;
  logic [PIX_W-1:0] w_rdata1;

  // An Intercambio arriving with FinCuadro counts as already pending.
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      r_banco   <= 1'b0;
      r_pending <= 1'b0;
    end else if (FinCuadro && (r_pending || Intercambio)) begin
      r_banco   <= ~r_banco;
      r_pending <= 1'b0;
    end else if (Intercambio) begin
      r_pending <= 1'b1;
    end
  end

  // Remember which bank a request read so a swap in flight cannot misroute it.
  always_ff @(posedge Reloj) begin
    if (Reset) begin
      r_s1_bank <= 1'b0;
    end else begin
      r_s1_bank <= r_banco;
    end
  end

  vram_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_bank0 (
    .i_clk   (Reloj),
    .i_we    (w_clr_we || (w_wr_fire && r_banco)),
    .i_waddr (w_we_addr),
    .i_wdata (w_we_data),
    .i_re    (w_rd_en && !r_banco),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata0)
  );

  vram_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_bank1 (
    .i_clk   (Reloj),
    .i_we    (w_clr_we || (w_wr_fire && !r_banco)),
    .i_waddr (w_we_addr),
    .i_wdata (w_we_data),
    .i_re    (w_rd_en && r_banco),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata1)
  );

  assign w_rd_data   = r_s1_bank ? w_rdata1 : w_rdata0;
  assign BancoActivo = r_banco;
`else
  logic w_unused;

  assign w_unused = ^{Intercambio, FinCuadro};

  vram_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_bank0 (
    .i_clk   (Reloj),
    .i_we    (w_clr_we || w_wr_fire),
    .i_waddr (w_we_addr),
    .i_wdata (w_we_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign BancoActivo = 1'b0;
`endif

  // Read pipeline: stage 1 carries the request flags alongside the bank's
  // registered read, stage 2 registers the final pixel.
  logic             r_s1_valid;
  logic             r_s1_oor;
  logic             r_s1_zero;
  logic             r_pv;
  logic             r_oor;
  logic [PIX_W-1:0] r_pixel;

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_oor   <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_pv       <= 1'b0;
      r_oor      <= 1'b0;
      r_pixel    <= '0;
    end else begin
      r_s1_valid <= LeerValido;
      r_s1_oor   <= w_rd_oor;
      r_s1_zero  <= (r_state == VR_CLEAR);
      r_pv       <= r_s1_valid;
      r_oor      <= r_s1_valid && r_s1_oor;
      r_pixel    <= (r_s1_valid && !r_s1_oor && !r_s1_zero) ? w_rd_data : '0;
    end
  end

  assign PixelValido = r_pv;
  assign FueraRango  = r_oor;
  assign Pixel       = r_pixel;

endmodule

// File: tb/tb_vram_buffer_dual.sv
// tb/tb_vram_buffer_dual.sv - scoreboard bench for vram_buffer_dual (reduced 32x24 frame)

module tb_vram_buffer_dual;

  localparam int H  = 32;
  localparam int V  = 24;
  localparam int PW = 4;
  localparam int N  = H * V;
`ifdef VRAM_DOUBLE_BUFFER_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic [10:0]   Fila = '0, Columna = '0, EscFila = '0, EscColumna = '0;
  logic          LeerValido = 1'b0, EscValido = 1'b0, Intercambio = 1'b0, FinCuadro = 1'b0;
  logic [PW-1:0] EscDato = '0;
  logic [PW-1:0] Pixel;
  logic          PixelValido, FueraRango, EscListo, BancoActivo;

  always #5 clk = ~clk;

  vram_buffer_dual #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW)) dut (
    .Reloj(clk), .Reset(Reset),
    .Fila(Fila), .Columna(Columna), .LeerValido(LeerValido),
    .Pixel(Pixel), .PixelValido(PixelValido), .FueraRango(FueraRango),
    .EscFila(EscFila), .EscColumna(EscColumna), .EscDato(EscDato),
    .EscValido(EscValido), .EscListo(EscListo),
    .Intercambio(Intercambio), .FinCuadro(FinCuadro), .BancoActivo(BancoActivo)
  );

  int tests_run = 0;
  int failed    = 0;
  int cyc       = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] pix;
    logic          oor;
    int            due;
  } exp_t;
  exp_t sbq[$];

  logic [PW-1:0] mdl [0:1][0:N-1];
  int            mbank    = 0;
  bit            clearing = 1'b0;

  // Scoreboard: every PixelValido pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (PixelValido === 1'b1) begin
      exp_t e;
      tests_run++;
      if (sbq.size() == 0) begin
        failed++;
        $display("FAIL sb_extra_pulse: PixelValido at cycle %0d with no outstanding read", cyc);
      end else begin
        e = sbq.pop_front();
        if (Pixel !== e.pix || FueraRango !== e.oor || cyc !== e.due) begin
          failed++;
          $display("FAIL sb_read: got pix=%0h oor=%0b cyc=%0d, need pix=%0h oor=%0b cyc=%0d",
                   Pixel, FueraRango, cyc, e.pix, e.oor, e.due);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic idle(input int n);
    LeerValido  = 1'b0;
    EscValido   = 1'b0;
    Intercambio = 1'b0;
    FinCuadro   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < N; a++) mdl[b][a] = '0;
    mbank = 0;
  endtask

  // Issue a read this cycle and queue its expected response.
  task automatic rd_push(input int f, input int c);
    exp_t e;
    Fila       = 11'(f);
    Columna    = 11'(c);
    LeerValido = 1'b1;
    e.oor = (f >= V) || (c >= H);
    e.pix = (e.oor || clearing) ? '0 : mdl[mbank][f*H+c];
    e.due = cyc + 2;
    sbq.push_back(e);
  endtask

  task automatic wr_set(input int f, input int c, input int d);
    EscFila    = 11'(f);
    EscColumna = 11'(c);
    EscDato    = PW'(d);
    EscValido  = 1'b1;
    if (f < V && c < H) mdl[mbank ^ DBL][f*H+c] = PW'(d);
  endtask

  // Counts cycles with EscListo low starting at the current negedge; reads
  // the far corner mid-sweep, which must come back as 0.
  task automatic count_clear(output int cnt);
    cnt = 0;
    while (EscListo !== 1'b1 && cnt < 2 * N) begin
      if (cnt == 5) rd_push(V - 1, H - 1);
      if (cnt == 6) LeerValido = 1'b0;
      @(negedge clk);
      cnt++;
    end
    clearing = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    Reset = 1'b1;
    idle(2);
    tests_run++;
    if (PixelValido !== 1'b0 || FueraRango !== 1'b0 || Pixel !== '0) begin
      failed++;
      $display("FAIL reset_read_outputs: got pv=%0b oor=%0b pix=%0h, need 0 0 0", PixelValido, FueraRango, Pixel);
    end
    tests_run++;
    if (EscListo !== 1'b0) begin
      failed++;
      $display("FAIL reset_esclisto: got %0b, need 0", EscListo);
    end
    tests_run++;
    if (BancoActivo !== 1'b0) begin
      failed++;
      $display("FAIL reset_banco: got %0b, need 0", BancoActivo);
    end
    Reset = 1'b0;
    clear_model();
    clearing = 1'b1;
    count_clear(cnt);
    tests_run++;
    if (cnt !== N) begin
      failed++;
      $display("FAIL clear_length: got %0d cycles with EscListo low, need %0d", cnt, N);
    end
    rd_push(0, 0);
    @(negedge clk);
    rd_push(V - 1, H - 1);
    @(negedge clk);
    rd_push(12, 7);
    @(negedge clk);
    idle(3);
  endtask

  task automatic test_write_read();
    tests_run++;
    if (EscListo !== 1'b1) begin
      failed++;
      $display("FAIL idle_esclisto: got %0b, need 1", EscListo);
    end
    wr_set(10, 20, 1);
    @(negedge clk);
    idle(2);
    rd_push(10, 20);
    @(negedge clk);
    idle(4);
  endtask

  task automatic test_out_of_range();
    wr_set(1, 0, 3);
    @(negedge clk);
    wr_set(0, H, 15);
    @(negedge clk);
    wr_set(V, 0, 15);
    @(negedge clk);
    idle(1);
    rd_push(V, 0);
    @(negedge clk);
    rd_push(0, H);
    @(negedge clk);
    rd_push(2047, 2047);
    @(negedge clk);
    rd_push(1, 0);
    @(negedge clk);
    idle(4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      wr_set(0, i, (i * 7 + 3) & 15);
      @(negedge clk);
    end
    idle(1);
    for (int i = 0; i < 16; i++) begin
      rd_push(0, i);
      @(negedge clk);
    end
    idle(4);
    tests_run++;
    if (sbq.size() != 0) begin
      failed++;
      $display("FAIL b2b_drain: got %0d reads outstanding, need 0", sbq.size());
    end
    wr_set(2, 2, 5);
    @(negedge clk);
    idle(1);
    rd_push(2, 2);
    wr_set(2, 2, 9);
    @(negedge clk);
    idle(1);
    rd_push(2, 2);
    @(negedge clk);
    idle(4);
  endtask

  task automatic test_swap();
    wr_set(0, 0, 1);
    @(negedge clk);
    idle(1);
    rd_push(0, 0);
    @(negedge clk);
    idle(3);
    Intercambio = 1'b1;
    @(negedge clk);
    idle(2);
    tests_run++;
    if (BancoActivo !== 1'b0) begin
      failed++;
      $display("FAIL swap_early: got BancoActivo=%0b before FinCuadro, need 0", BancoActivo);
    end
    FinCuadro = 1'b1;
    mbank ^= DBL;
    @(negedge clk);
    idle(0);
    tests_run++;
    if (BancoActivo !== 1'(mbank)) begin
      failed++;
      $display("FAIL swap_on_frame: got BancoActivo=%0b, need %0b", BancoActivo, 1'(mbank));
    end
    rd_push(0, 0);
    @(negedge clk);
    idle(3);
    FinCuadro = 1'b1;
    @(negedge clk);
    idle(0);
    tests_run++;
    if (BancoActivo !== 1'(mbank)) begin
      failed++;
      $display("FAIL swap_no_pending: got BancoActivo=%0b, need %0b", BancoActivo, 1'(mbank));
    end
    Intercambio = 1'b1;
    FinCuadro   = 1'b1;
    mbank ^= DBL;
    @(negedge clk);
    idle(0);
    tests_run++;
    if (BancoActivo !== 1'(mbank)) begin
      failed++;
      $display("FAIL swap_same_cycle: got BancoActivo=%0b, need %0b", BancoActivo, 1'(mbank));
    end
    rd_push(10, 20);
    @(negedge clk);
    idle(4);
  endtask

  task automatic test_reset_midclear();
    int cnt;
    wr_set(V - 1, H - 1, 10);
    @(negedge clk);
    idle(1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    clear_model();
    clearing = 1'b1;
    repeat (500) @(negedge clk);
    tests_run++;
    if (EscListo !== 1'b0) begin
      failed++;
      $display("FAIL midclear_busy: got EscListo=%0b, need 0", EscListo);
    end
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    count_clear(cnt);
    tests_run++;
    if (cnt !== N) begin
      failed++;
      $display("FAIL midclear_restart: got %0d cycles with EscListo low, need %0d", cnt, N);
    end
    tests_run++;
    if (BancoActivo !== 1'b0) begin
      failed++;
      $display("FAIL midclear_banco: got %0b, need 0", BancoActivo);
    end
    rd_push(V - 1, H - 1);
    @(negedge clk);
    rd_push(10, 20);
    @(negedge clk);
    idle(4);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_swap();
    test_reset_midclear();
    idle(4);
    tests_run++;
    if (sbq.size() != 0) begin
      failed++;
      $display("FAIL final_drain: got %0d reads without PixelValido, need 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
